// File: rtl/toggle_handshake_receiver_pkg.sv
// ============================================================================
// Module      : toggle_handshake_receiver_pkg
// Description : Shared state encoding and parameter defaults for the receiver.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package toggle_handshake_receiver_pkg;

    localparam int DATA_W_DEFAULT      = 8;
    localparam int SYNC_STAGES_DEFAULT = 2;
    localparam int CNT_W_DEFAULT       = 8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } rx_state_e;

endpackage

`default_nettype wire

// File: rtl/toggle_handshake_receiver_sync_detect.sv
// ============================================================================
// Module      : toggle_sync_detect
// Description : Request-level synchroniser with a one-cycle toggle-event pulse.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module toggle_sync_detect
    import toggle_handshake_receiver_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic lvl_i,
    output logic lvl_o,
    output logic evt_o
);

    // SYNC_STAGES must be at least 2 for the shift below to be well formed.
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], lvl_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign lvl_o = sync_q[SYNC_STAGES-1];
    assign evt_o = sync_q[SYNC_STAGES-1] ^ prev_q;

endmodule

`default_nettype wire

// File: rtl/toggle_handshake_receiver.sv
// ============================================================================
// Module      : toggle_handshake_receiver
// Description : Two-phase toggle receiver presenting words on valid/ready.
//               Optional parity check enabled by TOGGLE_RX_PARITY_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module toggle_handshake_receiver
    import toggle_handshake_receiver_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEFAULT,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT,
    parameter int CNT_W       = CNT_W_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_tgl_i,
    input  logic [DATA_W-1:0] data_i,
`ifdef TOGGLE_RX_PARITY_EN
    input  logic              par_i,
    output logic              par_err_o,
`endif
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic              ack_tgl_o,
    output logic              overrun_o,
    output logic [CNT_W-1:0]  evt_count_o
);

    logic              tgl_evt;
    logic              sync_lvl_unused;
    rx_state_e         state_q;
    rx_state_e         state_d;
    logic              capture;
    logic              handshake;
    logic              drop_evt;
    logic [DATA_W-1:0] data_q;
    logic              ack_q;
    logic              overrun_q;
    logic [CNT_W-1:0]  cnt_q;

    toggle_sync_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_detect (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .lvl_i  (req_tgl_i),
        .lvl_o  (sync_lvl_unused),
        .evt_o  (tgl_evt)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (tgl_evt) state_d = ST_HOLD;
            ST_HOLD: if (ready_i) state_d = ST_IDLE;
        endcase
    end

    // A toggle seen while holding is dropped, even if the word leaves this cycle.
    always_comb begin
        valid_o   = (state_q == ST_HOLD);
        capture   = (state_q == ST_IDLE) && tgl_evt;
        handshake = (state_q == ST_HOLD) && ready_i;
        drop_evt  = (state_q == ST_HOLD) && tgl_evt;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q    <= '0;
            ack_q     <= 1'b0;
            overrun_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            if (capture) begin
                data_q <= data_i;
            end
            if (handshake) begin
                ack_q <= ~ack_q;
                cnt_q <= cnt_q + 1'b1;
            end
            if (drop_evt) begin
                overrun_q <= 1'b1;
            end
        end
    end

`ifdef TOGGLE_RX_PARITY_EN
    logic par_err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            par_err_q <= 1'b0;
        end else if (capture) begin
            par_err_q <= (^data_i) ^ par_i;
        end else if (handshake) begin
            par_err_q <= 1'b0;
        end
    end

    assign par_err_o = par_err_q;
`endif

    assign data_o      = data_q;
    assign ack_tgl_o   = ack_q;
    assign overrun_o   = overrun_q;
    assign evt_count_o = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_toggle_handshake_receiver.sv
// ============================================================================
// Module      : tb_toggle_handshake_receiver
// Description : Scoreboard bench for toggle_handshake_receiver.
// Revision    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_toggle_handshake_receiver;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       req_tgl = 1'b0;
    logic       ready   = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       valid;
    logic       ack_tgl;
    logic       overrun;
    logic [7:0] evt_count;
`ifdef TOGGLE_RX_PARITY_EN
    logic       par_in = 1'b0;
    logic       par_err;
`endif

    int         total = 0;
    int         bad   = 0;
    logic [7:0] sb_q[$];
    logic [7:0] mon_exp;
    logic       exp_ack = 1'b0;
    logic [7:0] exp_cnt = 8'h00;

    always #5 clk = ~clk;

    toggle_handshake_receiver #(
        .DATA_W      (8),
        .SYNC_STAGES (2),
        .CNT_W       (8)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_tgl_i   (req_tgl),
        .data_i      (data_in),
`ifdef TOGGLE_RX_PARITY_EN
        .par_i       (par_in),
        .par_err_o   (par_err),
`endif
        .ready_i     (ready),
        .data_o      (data_out),
        .valid_o     (valid),
        .ack_tgl_o   (ack_tgl),
        .overrun_o   (overrun),
        .evt_count_o (evt_count)
    );

    // Consumer side: every accepted word must be the oldest one expected.
    always @(negedge clk) begin
        if (rst_n && valid && ready) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL scoreboard: unexpected word %h accepted, none pending", data_out);
            end else begin
                mon_exp = sb_q.pop_front();
                if (data_out !== mon_exp) begin
                    bad++;
                    $display("FAIL scoreboard data: got %h want %h", data_out, mon_exp);
                end
            end
            exp_ack = ~exp_ack;
            exp_cnt = exp_cnt + 8'd1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        req_tgl = 1'b0;
        ready   = 1'b0;
        sb_q.delete();
        exp_ack = 1'b0;
        exp_cnt = 8'h00;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic send(input logic [7:0] w, input bit expect_capture);
        data_in = w;
        req_tgl = ~req_tgl;
        if (expect_capture) sb_q.push_back(w);
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        req_tgl = 1'b1;
        data_in = 8'h5A;
        ready   = 1'b0;
        tick();
        tick();
        total++; if (valid !== 1'b0)       begin bad++; $display("FAIL reset valid: got %b want 0", valid); end
        total++; if (data_out !== 8'h00)   begin bad++; $display("FAIL reset data: got %h want 00", data_out); end
        total++; if (ack_tgl !== 1'b0)     begin bad++; $display("FAIL reset ack: got %b want 0", ack_tgl); end
        total++; if (overrun !== 1'b0)     begin bad++; $display("FAIL reset overrun: got %b want 0", overrun); end
        total++; if (evt_count !== 8'h00)  begin bad++; $display("FAIL reset count: got %h want 00", evt_count); end
        sb_q.push_back(8'h5A);
        rst_n = 1'b1;
        tick();
        tick();
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset early valid: got %b want 0", valid); end
        tick();
        total++; if (valid !== 1'b1)     begin bad++; $display("FAIL reset release valid: got %b want 1", valid); end
        total++; if (data_out !== 8'h5A) begin bad++; $display("FAIL reset release data: got %h want 5a", data_out); end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        total++; if (ack_tgl !== exp_ack) begin bad++; $display("FAIL reset ack after use: got %b want %b", ack_tgl, exp_ack); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (ack_tgl !== 1'b0 || evt_count !== 8'h00) begin
            bad++; $display("FAIL async reset: ack %b count %h want 0 00", ack_tgl, evt_count);
        end
        do_reset();
    endtask

    task automatic test_basic();
        ready = 1'b1;
        send(8'hA5, 1'b1);
        tick();
        tick();
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL basic early valid: got %b want 0", valid); end
        tick();
        total++; if (valid !== 1'b1)     begin bad++; $display("FAIL basic valid: got %b want 1", valid); end
        total++; if (data_out !== 8'hA5) begin bad++; $display("FAIL basic data: got %h want a5", data_out); end
        tick();
        total++; if (valid !== 1'b0)      begin bad++; $display("FAIL basic valid drop: got %b want 0", valid); end
        total++; if (ack_tgl !== 1'b1)    begin bad++; $display("FAIL basic ack: got %b want 1", ack_tgl); end
        total++; if (evt_count !== 8'd1)  begin bad++; $display("FAIL basic count: got %0d want 1", evt_count); end
    endtask

    task automatic test_stall();
        int n;
        ready = 1'b0;
        send(8'h3C, 1'b1);
        n = 0;
        while (valid !== 1'b1 && n < 8) begin tick(); n++; end
        total++; if (valid !== 1'b1) begin bad++; $display("FAIL stall timeout: valid %b want 1", valid); end
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if (valid !== 1'b1 || data_out !== 8'h3C || ack_tgl !== exp_ack) begin
                bad++;
                $display("FAIL stall hold cycle %0d: valid %b data %h ack %b want 1 3c %b",
                         i, valid, data_out, ack_tgl, exp_ack);
            end
        end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        total++; if (valid !== 1'b0)       begin bad++; $display("FAIL stall release valid: got %b want 0", valid); end
        total++; if (ack_tgl !== exp_ack)  begin bad++; $display("FAIL stall ack: got %b want %b", ack_tgl, exp_ack); end
        total++; if (evt_count !== exp_cnt) begin bad++; $display("FAIL stall count: got %0d want %0d", evt_count, exp_cnt); end
    endtask

    task automatic test_overrun();
        ready = 1'b0;
        send(8'h11, 1'b1);
        for (int i = 0; i < 5; i++) tick();
        send(8'h22, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        total++; if (overrun !== 1'b1)   begin bad++; $display("FAIL overrun flag: got %b want 1", overrun); end
        total++; if (data_out !== 8'h11) begin bad++; $display("FAIL overrun data: got %h want 11", data_out); end
        total++; if (valid !== 1'b1)     begin bad++; $display("FAIL overrun valid: got %b want 1", valid); end
        ready = 1'b1;
        tick();
        total++; if (ack_tgl !== exp_ack) begin bad++; $display("FAIL overrun ack: got %b want %b", ack_tgl, exp_ack); end
        for (int i = 0; i < 6; i++) tick();
        ready = 1'b0;
        total++; if (valid !== 1'b0)        begin bad++; $display("FAIL overrun extra valid: got %b want 0", valid); end
        total++; if (ack_tgl !== exp_ack)   begin bad++; $display("FAIL overrun extra ack: got %b want %b", ack_tgl, exp_ack); end
        total++; if (overrun !== 1'b1)      begin bad++; $display("FAIL overrun sticky: got %b want 1", overrun); end
        total++; if (evt_count !== exp_cnt) begin bad++; $display("FAIL overrun count: got %0d want %0d", evt_count, exp_cnt); end
    endtask

    task automatic test_wrap();
        int n;
        int stuck;
        do_reset();
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL wrap overrun cleared: got %b want 0", overrun); end
        ready = 1'b1;
        stuck = 0;
        for (int i = 0; i < 256; i++) begin
            send(8'(i * 7 + 3), 1'b1);
            n = 0;
            while (valid !== 1'b1 && n < 8) begin tick(); n++; end
            if (valid !== 1'b1) stuck++;
            tick();
        end
        ready = 1'b0;
        total++; if (stuck != 0)            begin bad++; $display("FAIL wrap timeouts: got %0d want 0", stuck); end
        total++; if (evt_count !== 8'h00)   begin bad++; $display("FAIL wrap count: got %0d want 0", evt_count); end
        total++; if (ack_tgl !== 1'b0)      begin bad++; $display("FAIL wrap ack: got %b want 0", ack_tgl); end
        total++; if (sb_q.size() != 0)      begin bad++; $display("FAIL wrap pending words: got %0d want 0", sb_q.size()); end
    endtask

    task automatic test_back_to_back();
        int n;
        ready = 1'b1;
        send(8'hC3, 1'b1);
        n = 0;
        while (valid !== 1'b1 && n < 8) begin tick(); n++; end
        total++; if (valid !== 1'b1) begin bad++; $display("FAIL b2b first timeout: valid %b want 1", valid); end
        send(8'h96, 1'b1);
        tick();
        tick();
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL b2b gap valid: got %b want 0", valid); end
        tick();
        total++; if (valid !== 1'b1)     begin bad++; $display("FAIL b2b second valid: got %b want 1", valid); end
        total++; if (data_out !== 8'h96) begin bad++; $display("FAIL b2b second data: got %h want 96", data_out); end
        tick();
        ready = 1'b0;
        total++; if (evt_count !== exp_cnt) begin bad++; $display("FAIL b2b count: got %0d want %0d", evt_count, exp_cnt); end
        total++; if (overrun !== 1'b0)      begin bad++; $display("FAIL b2b overrun: got %b want 0", overrun); end
    endtask

`ifdef TOGGLE_RX_PARITY_EN
    task automatic test_parity();
        int n;
        do_reset();
        par_in = 1'b0;
        send(8'h07, 1'b1);
        n = 0;
        while (valid !== 1'b1 && n < 8) begin tick(); n++; end
        total++; if (par_err !== 1'b1) begin bad++; $display("FAIL parity bad word: got %b want 1", par_err); end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        total++; if (par_err !== 1'b0) begin bad++; $display("FAIL parity clear: got %b want 0", par_err); end
        par_in = 1'b1;
        send(8'h07, 1'b1);
        n = 0;
        while (valid !== 1'b1 && n < 8) begin tick(); n++; end
        total++; if (par_err !== 1'b0) begin bad++; $display("FAIL parity good word: got %b want 0", par_err); end
        ready = 1'b1;
        tick();
        ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_overrun();
        test_wrap();
        test_back_to_back();
`ifdef TOGGLE_RX_PARITY_EN
        test_parity();
`endif
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
